// File: rtl/kgp_pkg.sv
// rtl/kgp_pkg.sv - kill/generate/propagate encoding and prefix combine operator
package kgp_pkg;

  typedef logic [1:0] kgp_t;

  localparam kgp_t KGP_KILL = 2'b00;
  localparam kgp_t KGP_PROP = 2'b01;
  localparam kgp_t KGP_GEN  = 2'b10;

  localparam int PREFIX_LEVELS = 5;

  // hi o lo: a definite hi element wins, a propagating one defers to lo
  function automatic kgp_t kgp_combine(kgp_t hi, kgp_t lo);
    case (hi)
      KGP_KILL: return KGP_KILL;
      KGP_GEN:  return KGP_GEN;
      default:  return lo;
    endcase
  endfunction

  function automatic kgp_t kgp_bit(logic a, logic b);
    if (a & b) return KGP_GEN;
    if (~a & ~b) return KGP_KILL;
    return KGP_PROP;
  endfunction

endpackage

// File: rtl/kgp_pipelined_subtractor_if.sv
// rtl/kgp_pipelined_subtractor_if.sv - operand/result handshake bundle of the subtractor
interface kgp_pipelined_subtractor_if #(
  parameter int WIDTH = 32
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] D;
  logic             Bo;
  logic             N;
  logic             Z;
  logic             V;

  modport master (
    output in_valid, A, B, out_ready,
    input  in_ready, out_valid, D, Bo, N, Z, V
  );

  modport slave (
    input  in_valid, A, B, out_ready,
    output in_ready, out_valid, D, Bo, N, Z, V
  );

endinterface

// File: rtl/kgp_prefix_level.sv
// rtl/kgp_prefix_level.sv - one recursive-doubling level: element i absorbs element i-K
module kgp_prefix_level
  import kgp_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int K     = 1
) (
  input  kgp_t [WIDTH-1:0] prefix_in,
  output kgp_t [WIDTH-1:0] prefix_out
);

  for (genvar i = 0; i < WIDTH; i++) begin : g_elem
    if (i >= K) begin : g_combine
      assign prefix_out[i] = kgp_combine(prefix_in[i], prefix_in[i-K]);
    end else begin : g_pass
      assign prefix_out[i] = prefix_in[i];
    end
  end

endmodule

// File: rtl/kgp_pipelined_subtractor.sv
// rtl/kgp_pipelined_subtractor.sv - 3-stage KGP prefix subtractor D = A + ~B + 1 with N/Z/V/borrow
module kgp_pipelined_subtractor
  import kgp_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int LEVELS_S2 = 3
) (
  input logic                       clk,
  input logic                       rst_n,
  kgp_pipelined_subtractor_if.slave bus
);

  localparam int LEVELS_S3 = PREFIX_LEVELS - LEVELS_S2;

  logic en;
  logic v1, v2, v3;

  logic [WIDTH-1:0] s1_a, s1_nb;
  kgp_t [WIDTH-1:0] s1_kgp;
  logic [WIDTH-1:0] s2_a, s2_nb;
  kgp_t [WIDTH-1:0] s2_kgp;

  logic [WIDTH-1:0] d_q;
  logic             bo_q, n_q, z_q, ov_q;

  // The whole pipe advances together; bubbles are intentionally not squeezed out
  assign en           = ~(v3 & ~bus.out_ready);
  assign bus.in_ready = en;

  logic [WIDTH-1:0] nb_in;
  kgp_t [WIDTH-1:0] bit_kgp;

  assign nb_in = ~bus.B;

  // Carry-in of 1 folded into element 0 so the prefix at bit i already includes it
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit_kgp
    if (i == 0) begin : g_seed
      assign bit_kgp[i] = kgp_combine(kgp_bit(bus.A[i], nb_in[i]), KGP_GEN);
    end else begin : g_plain
      assign bit_kgp[i] = kgp_bit(bus.A[i], nb_in[i]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1     <= 1'b0;
      s1_a   <= '0;
      s1_nb  <= '0;
      s1_kgp <= '0;
    end else if (en) begin
      v1 <= bus.in_valid;
      if (bus.in_valid) begin
        s1_a   <= bus.A;
        s1_nb  <= nb_in;
        s1_kgp <= bit_kgp;
      end
    end
  end

  kgp_t [WIDTH-1:0] s2_chain [LEVELS_S2+1];

  assign s2_chain[0] = s1_kgp;

  for (genvar l = 0; l < LEVELS_S2; l++) begin : g_s2_level
    kgp_prefix_level #(
      .WIDTH (WIDTH),
      .K     (1 << l)
    ) u_level (
      .prefix_in  (s2_chain[l]),
      .prefix_out (s2_chain[l+1])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v2     <= 1'b0;
      s2_a   <= '0;
      s2_nb  <= '0;
      s2_kgp <= '0;
    end else if (en) begin
      v2 <= v1;
      if (v1) begin
        s2_a   <= s1_a;
        s2_nb  <= s1_nb;
        s2_kgp <= s2_chain[LEVELS_S2];
      end
    end
  end

  kgp_t [WIDTH-1:0] s3_chain [LEVELS_S3+1];

  assign s3_chain[0] = s2_kgp;

  for (genvar l = 0; l < LEVELS_S3; l++) begin : g_s3_level
    kgp_prefix_level #(
      .WIDTH (WIDTH),
      .K     (1 << (l + LEVELS_S2))
    ) u_level (
      .prefix_in  (s3_chain[l]),
      .prefix_out (s3_chain[l+1])
    );
  end

  kgp_t [WIDTH-1:0] pfx;
  logic [WIDTH-1:0] carry;
  logic [WIDTH-1:0] sum;
  logic             carry_out;
  logic             ovf;

  assign pfx = s3_chain[LEVELS_S3];

  // After the last level every element is resolved to KILL or GEN
  for (genvar i = 0; i < WIDTH; i++) begin : g_carry
    if (i == 0) begin : g_cin
      assign carry[i] = 1'b1;
    end else begin : g_cprefix
      assign carry[i] = (pfx[i-1] == KGP_GEN);
    end
  end

  assign sum       = s2_a ^ s2_nb ^ carry;
  assign carry_out = (pfx[WIDTH-1] == KGP_GEN);
  // A and B differ in sign exactly when A and ~B agree
  assign ovf       = (s2_a[WIDTH-1] == s2_nb[WIDTH-1]) && (sum[WIDTH-1] != s2_a[WIDTH-1]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v3   <= 1'b0;
      d_q  <= '0;
      bo_q <= 1'b0;
      n_q  <= 1'b0;
      z_q  <= 1'b0;
      ov_q <= 1'b0;
    end else if (en) begin
      v3 <= v2;
      if (v2) begin
        d_q  <= sum;
        bo_q <= ~carry_out;
        n_q  <= sum[WIDTH-1];
        z_q  <= (sum == '0);
        ov_q <= ovf;
      end
    end
  end

  assign bus.out_valid = v3;
  assign bus.D         = d_q;
  assign bus.Bo        = bo_q;
  assign bus.N         = n_q;
  assign bus.Z         = z_q;
  assign bus.V         = ov_q;

endmodule

// File: tb/tb_kgp_pipelined_subtractor.sv
// tb/tb_kgp_pipelined_subtractor.sv - directed self-checking bench for kgp_pipelined_subtractor
module tb_kgp_pipelined_subtractor;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  kgp_pipelined_subtractor_if #(.WIDTH(32)) bus ();

  kgp_pipelined_subtractor #(
    .WIDTH     (32),
    .LEVELS_S2 (3)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Presents one operand pair for a single cycle and waits for its result
  task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] d, output logic [3:0] flags, output int lat);
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.A        = a;
    bus.B        = b;
    @(negedge clk);
    bus.in_valid = 1'b0;
    lat = 1;
    while (!bus.out_valid && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    if (!bus.out_valid) lat = -1;
    d     = bus.D;
    flags = {bus.Bo, bus.N, bus.Z, bus.V};
  endtask

  task automatic test_reset();
    rst_n         = 1'b0;
    bus.in_valid  = 1'b1;
    bus.A         = 32'd5;
    bus.B         = 32'd5;
    bus.out_ready = 1'b0;
    #3;
    repeat (2) begin
      @(negedge clk);
      checks++;
      if (bus.out_valid !== 1'b0) begin
        errors++; $display("FAIL reset_out_valid: got %b expected 0", bus.out_valid);
      end
      checks++;
      if (bus.D !== 32'd0 || {bus.Bo, bus.N, bus.Z, bus.V} !== 4'b0000) begin
        errors++; $display("FAIL reset_outputs: got D=%h flags=%b expected D=0 flags=0000",
                           bus.D, {bus.Bo, bus.N, bus.Z, bus.V});
      end
      checks++;
      if (bus.in_ready !== 1'b1) begin
        errors++; $display("FAIL reset_in_ready: got %b expected 1", bus.in_ready);
      end
    end
    bus.in_valid = 1'b0;
    rst_n        = 1'b1;
    repeat (4) @(negedge clk);
    checks++;
    if (bus.out_valid !== 1'b0) begin
      errors++; $display("FAIL reset_idle: got out_valid=%b expected 0", bus.out_valid);
    end
    bus.out_ready = 1'b1;
  endtask

  task automatic test_basic();
    logic [31:0] d;
    logic [3:0]  f;
    int          lat;
    run_op(32'd5, 32'd3, d, f, lat);
    checks++;
    if (lat !== 3) begin
      errors++; $display("FAIL basic_latency: got %0d expected 3", lat);
    end
    checks++;
    if (d !== 32'd2 || f !== 4'b0000) begin
      errors++; $display("FAIL basic_5_3: got D=%h BoNZV=%b expected D=2 BoNZV=0000", d, f);
    end
    @(negedge clk);
    checks++;
    if (bus.out_valid !== 1'b0) begin
      errors++; $display("FAIL basic_single_pulse: got out_valid=%b expected 0", bus.out_valid);
    end
    run_op(32'hDEADBEEF, 32'd0, d, f, lat);
    checks++;
    if (lat !== 3 || d !== 32'hDEADBEEF || f !== 4'b0100) begin
      errors++; $display("FAIL b_zero: got lat=%0d D=%h BoNZV=%b expected lat=3 D=deadbeef BoNZV=0100",
                         lat, d, f);
    end
  endtask

  task automatic test_borrow();
    logic [31:0] d;
    logic [3:0]  f;
    int          lat;
    run_op(32'd0, 32'd1, d, f, lat);
    checks++;
    if (lat !== 3 || d !== 32'hFFFFFFFF || f !== 4'b1100) begin
      errors++; $display("FAIL borrow_0_1: got lat=%0d D=%h BoNZV=%b expected lat=3 D=ffffffff BoNZV=1100",
                         lat, d, f);
    end
    run_op(32'd3, 32'd5, d, f, lat);
    checks++;
    if (lat !== 3 || d !== 32'hFFFFFFFE || f !== 4'b1100) begin
      errors++; $display("FAIL borrow_3_5: got lat=%0d D=%h BoNZV=%b expected lat=3 D=fffffffe BoNZV=1100",
                         lat, d, f);
    end
  endtask

  task automatic test_overflow();
    logic [31:0] d;
    logic [3:0]  f;
    int          lat;
    run_op(32'h80000000, 32'd1, d, f, lat);
    checks++;
    if (lat !== 3 || d !== 32'h7FFFFFFF || f !== 4'b0001) begin
      errors++; $display("FAIL ovf_min_minus_1: got lat=%0d D=%h BoNZV=%b expected lat=3 D=7fffffff BoNZV=0001",
                         lat, d, f);
    end
    run_op(32'h7FFFFFFF, 32'hFFFFFFFF, d, f, lat);
    checks++;
    if (lat !== 3 || d !== 32'h80000000 || f !== 4'b1101) begin
      errors++; $display("FAIL ovf_max_minus_m1: got lat=%0d D=%h BoNZV=%b expected lat=3 D=80000000 BoNZV=1101",
                         lat, d, f);
    end
  endtask

  task automatic test_equal();
    logic [31:0] d;
    logic [3:0]  f;
    int          lat;
    run_op(32'h12345678, 32'h12345678, d, f, lat);
    checks++;
    if (lat !== 3 || d !== 32'd0 || f !== 4'b0010) begin
      errors++; $display("FAIL equal_ops: got lat=%0d D=%h BoNZV=%b expected lat=3 D=0 BoNZV=0010",
                         lat, d, f);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] got[$];
    logic [31:0] exp_d [4];
    exp_d = '{32'd9, 32'd18, 32'd27, 32'd36};
    @(negedge clk);
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.A = 32'd10; bus.B = 32'd1;
    @(negedge clk);
    bus.A = 32'd20; bus.B = 32'd2;
    @(negedge clk);
    bus.A = 32'd30; bus.B = 32'd3;
    @(negedge clk);
    checks++;
    if (bus.out_valid !== 1'b1 || bus.D !== 32'd9) begin
      errors++; $display("FAIL b2b_first: got out_valid=%b D=%0d expected 1 and 9", bus.out_valid, bus.D);
    end
    bus.A = 32'd40; bus.B = 32'd4;
    bus.out_ready = 1'b0;
    #1;
    checks++;
    if (bus.in_ready !== 1'b0) begin
      errors++; $display("FAIL b2b_stall_ready: got in_ready=%b expected 0", bus.in_ready);
    end
    repeat (2) begin
      @(negedge clk);
      checks++;
      if (bus.out_valid !== 1'b1 || bus.D !== 32'd9 || bus.in_ready !== 1'b0) begin
        errors++; $display("FAIL b2b_stall_hold: got out_valid=%b D=%0d in_ready=%b expected 1, 9, 0",
                           bus.out_valid, bus.D, bus.in_ready);
      end
    end
    bus.out_ready = 1'b1;
    if (bus.out_valid) got.push_back(bus.D);
    @(negedge clk);
    bus.in_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (bus.out_valid) got.push_back(bus.D);
      @(negedge clk);
    end
    checks++;
    if (got.size() !== 4) begin
      errors++; $display("FAIL b2b_count: got %0d results expected 4", got.size());
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (i >= got.size()) begin
        errors++; $display("FAIL b2b_result%0d: got none expected %0d", i, exp_d[i]);
      end else if (got[i] !== exp_d[i]) begin
        errors++; $display("FAIL b2b_result%0d: got %0d expected %0d", i, got[i], exp_d[i]);
      end
    end
  endtask

  task automatic test_reset_midflight();
    logic [31:0] d;
    logic [3:0]  f;
    int          lat;
    int          seen;
    @(negedge clk);
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.A = 32'd100; bus.B = 32'd1;
    @(negedge clk);
    bus.A = 32'd200; bus.B = 32'd2;
    @(negedge clk);
    bus.A = 32'd300; bus.B = 32'd3;
    @(posedge clk);
    #1;
    checks++;
    if (bus.out_valid !== 1'b1 || bus.D !== 32'd99) begin
      errors++; $display("FAIL midrst_inflight: got out_valid=%b D=%0d expected 1 and 99", bus.out_valid, bus.D);
    end
    #1;
    bus.in_valid = 1'b0;
    rst_n        = 1'b0;
    #1;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.D !== 32'd0 || bus.in_ready !== 1'b1) begin
      errors++; $display("FAIL midrst_async_clear: got out_valid=%b D=%h in_ready=%b expected 0, 0, 1",
                         bus.out_valid, bus.D, bus.in_ready);
    end
    #1;
    rst_n = 1'b1;
    seen  = 0;
    repeat (6) begin
      @(negedge clk);
      if (bus.out_valid) seen++;
    end
    checks++;
    if (seen !== 0) begin
      errors++; $display("FAIL midrst_no_stale: got %0d valid cycles expected 0", seen);
    end
    run_op(32'd7, 32'd7, d, f, lat);
    checks++;
    if (lat !== 3 || d !== 32'd0 || f !== 4'b0010) begin
      errors++; $display("FAIL midrst_recover: got lat=%0d D=%h BoNZV=%b expected lat=3 D=0 BoNZV=0010",
                         lat, d, f);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_basic();
    test_borrow();
    test_overflow();
    test_equal();
    test_back_to_back();
    test_reset_midflight();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
